// File: rtl/pulse_train_scheduler.sv
// pulse_train_scheduler: accepts 9-bit commands and emits a counted, abortable gen_clk train.
// Optional PULSE_SCHED_STATUS_EN adds trains_done, a wrapping count of normally completed trains.
module pulse_train_scheduler #(
    parameter int HALF_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [8:0]        data,
    input  logic [HALF_W-1:0] half_period,
    input  logic              abort,
    output logic              gen_clk,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pulse_cnt
`ifdef PULSE_SCHED_STATUS_EN
    ,
    output logic [7:0]        trains_done
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [HALF_W-1:0] half;
    logic [HALF_W-1:0] divider;
    logic last_fall;
    // The falling toggle that consumes the final period ends the train normally
    assign last_fall = (state == RUN) && !abort && (divider == '0) && gen_clk
                       && (pulse_cnt == CNT_W'(1));
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            gen_clk    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_ready <= 1'b1;
            pulse_cnt  <= '0;
            divider    <= '0;
            half       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (data_valid && data[8]) begin
                    data_ready <= 1'b0;
                    if (data[7:0] == 8'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        pulse_cnt <= CNT_W'(data[7:0]);
                        half      <= (half_period == '0) ? HALF_W'(1) : half_period;
                        divider   <= (half_period == '0) ? '0 : half_period - 1'b1;
                    end
                end
                RUN: if (abort) begin
                    gen_clk   <= 1'b0;
                    pulse_cnt <= '0;
                    divider   <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end else if (divider == '0) begin
                    gen_clk <= ~gen_clk;
                    divider <= half - 1'b1;
                    if (gen_clk) pulse_cnt <= pulse_cnt - 1'b1;
                    if (last_fall) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end else begin
                    divider <= divider - 1'b1;
                end
                DONE: begin
                    data_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef PULSE_SCHED_STATUS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) trains_done <= '0;
        else if (last_fall) trains_done <= trains_done + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pulse_train_scheduler.sv
// tb_pulse_train_scheduler: randomized and directed checks against an arithmetic timing model.
module tb_pulse_train_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [8:0] data = '0;
    logic [7:0] half_period = '0;
    logic       abort = 1'b0;
    logic       gen_clk, busy, done;
    logic [7:0] pulse_cnt;
    int vectors = 0;
    int miscompares = 0;
`ifdef PULSE_SCHED_STATUS_EN
    logic [7:0] trains_done;
    logic [7:0] exp_td = '0;
`endif

    pulse_train_scheduler dut (
        .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .data_ready(data_ready),
        .data(data), .half_period(half_period), .abort(abort), .gen_clk(gen_clk),
        .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
`ifdef PULSE_SCHED_STATUS_EN
        , .trains_done(trains_done)
`endif
    );

    always #5 clk = ~clk;

    // Issues one command and checks every cycle until the scheduler is idle again.
    // Expected waveform: after edge k of a train, gen_clk = floor(k/H) odd,
    // pulse_cnt = N - floor(k/2H), busy for k < 2HN, done at the end edge.
    task automatic run_cmd(input logic [8:0] d, input logic [7:0] hp, input int abort_at,
                           input string name);
        int h, n, last, stop;
        bit aborted;
        logic [11:0] exp, act;
        h = (hp == 0) ? 1 : int'(hp);
        n = int'(d[7:0]);
        last = 2 * h * n;
        aborted = d[8] && n > 0 && abort_at >= 1 && abort_at <= last;
        if (aborted) last = abort_at;
        stop = d[8] ? last + 1 : 3;
        data_valid = 1'b1;
        data = d;
        half_period = hp;
        @(posedge clk); #1;
        for (int k = 0; k <= stop; k++) begin
            if (d[8] && k < last)
                exp = {((k / h) % 2) == 1, 3'b100, 8'(n - k / (2 * h))};
            else if (d[8] && k == last)
                exp = {4'b0010, 8'h00};
            else
                exp = {4'b0001, 8'h00};
            act = {gen_clk, busy, done, data_ready, pulse_cnt};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL %s k=%0d {gen,busy,done,ready,cnt}: got %h want %h", name, k, act, exp);
            end
            data_valid = d[8] && k < last;
            data = {1'b1, 8'($urandom)};
            half_period = 8'($urandom);
            abort = (d[8] && k < last && k + 1 == abort_at) || (d[8] && k == last)
                    || (!d[8] && k < stop);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        data_valid = 1'b0;
`ifdef PULSE_SCHED_STATUS_EN
        if (d[8] && n > 0 && !aborted) exp_td++;
        vectors++;
        if (trains_done !== exp_td) begin
            miscompares++;
            $display("FAIL %s trains_done: got %0d want %0d", name, trains_done, exp_td);
        end
`endif
    endtask

    task automatic test_reset();
        data_valid = 1'b1;
        data = 9'h1FF;
        half_period = 8'd3;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({gen_clk, busy, done, data_ready, pulse_cnt} !== 12'h100) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %h want 100", i,
                         {gen_clk, busy, done, data_ready, pulse_cnt});
            end
        end
`ifdef PULSE_SCHED_STATUS_EN
        exp_td = '0;
        vectors++;
        if (trains_done !== 8'd0) begin
            miscompares++;
            $display("FAIL reset trains_done: got %0d want 0", trains_done);
        end
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_train();
        run_cmd(9'h103, 8'd12, 0, "train_3x12");
    endtask

    task automatic test_no_start();
        run_cmd(9'h005, 8'd7, 0, "no_start");
    endtask

    task automatic test_zero_count();
        run_cmd(9'h100, 8'd5, 0, "zero_count");
    endtask

    task automatic test_abort();
        run_cmd(9'h1FF, 8'd4, 17, "abort_after_2");
        run_cmd(9'h102, 8'd3, 12, "abort_on_last_fall");
    endtask

    task automatic test_half_zero();
        int cnt;
`ifdef PULSE_SCHED_STATUS_EN
        cnt = 256 - int'(exp_td);
`else
        cnt = 3;
`endif
        for (int i = 0; i < cnt; i++) run_cmd(9'h102, 8'd0, 0, "half_zero");
`ifdef PULSE_SCHED_STATUS_EN
        vectors++;
        if (trains_done !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap trains_done: got %0d want 0", trains_done);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [8:0] d;
            logic [7:0] hp;
            int ab;
            d = {($urandom % 4) != 0, 8'($urandom_range(0, 6))};
            hp = 8'($urandom_range(0, 5));
            ab = ($urandom % 3 == 0) ? int'($urandom_range(1, 60)) : 0;
            run_cmd(d, hp, ab, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(9'h101, 8'd1, 0, "b2b_a");
        run_cmd(9'h100, 8'd0, 0, "b2b_b");
        run_cmd(9'h102, 8'd2, 0, "b2b_c");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_train();
        test_no_start();
        test_zero_count();
        test_abort();
        test_back_to_back();
        test_random();
        test_half_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
